hilo_unit: RTL and testbench

- Execute/writeback-side owner of the architectural HI and LO registers.
- Consumes the per-instruction HI/LO write descriptor from decode (write_hilo_t) together with the multiply/divide opcode and operands.
- Commits MTHI/MTLO directly.
- Runs MULT/MULTU in a single registered cycle and DIV/DIVU on an iterative radix-2 divider.
- Raises busy to stall the pipeline while an operation is in flight.

---
 rtl/hilo_unit_pkg.sv | 32 +++
 rtl/hilo_unit_if.sv | 25 ++
 rtl/hilo_unit_div_radix2.sv | 57 +++++
 rtl/hilo_unit.sv | 123 ++++++++++++
 tb/tb_hilo_unit.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/hilo_unit_pkg.sv
// Shared types for the HI/LO unit: mult/div opcodes, FSM states and the decode-side HI/LO write descriptor.
package hilo_unit_pkg;

  localparam int DIV_ITERS = 32;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4
  } mdop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } hilo_state_t;

  typedef struct packed {
    logic        valid_hi;
    logic        valid_lo;
    logic [31:0] hi;
    logic [31:0] lo;
  } write_hilo_t;

  function automatic logic [31:0] neg_if(input logic cond, input logic [31:0] v);
    return cond ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_unit_if.sv
// Pipeline-to-HI/LO-unit bundle: instruction descriptor and operands in, busy and architectural HI/LO out.
interface hilo_if;
  import hilo_unit_pkg::*;

  logic        in_valid;
  write_hilo_t write_hilo;
  mdop_t       md_op;
  logic [31:0] vs;
  logic [31:0] vt;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output in_valid, write_hilo, md_op, vs, vt, flush,
    input  busy, hi, lo
  );

  modport slave (
    input  in_valid, write_hilo, md_op, vs, vt, flush,
    output busy, hi, lo
  );

endinterface

// File: rtl/hilo_unit_div_radix2.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Latency: DIV_ITERS cycles after start; done flags the cycle of the final iteration.
// Backpressure: none; start is ignored mid-run only by the caller, abort drops the run.
module div_radix2
  import hilo_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  localparam int CW = $clog2(DIV_ITERS);

  logic [CW-1:0] counter;
  logic          running;
  logic [31:0]   dvsr;
  logic [32:0]   partial;
  logic [33:0]   diff;

  // rem < dvsr always holds, so partial can reach 33 bits; a 34-bit subtract keeps the borrow honest.
  assign partial = {rem, quot[31]};
  assign diff    = {1'b0, partial} - {2'b00, dvsr};
  assign done    = running && (counter == CW'(DIV_ITERS - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      counter <= '0;
      running <= 1'b0;
      dvsr    <= '0;
      quot    <= '0;
      rem     <= '0;
    end else if (abort) begin
      counter <= '0;
      running <= 1'b0;
    end else if (start) begin
      quot    <= dividend;
      rem     <= '0;
      dvsr    <= divisor;
      counter <= '0;
      running <= 1'b1;
    end else if (running) begin
      rem     <= diff[33] ? partial[31:0] : diff[31:0];
      quot    <= {quot[30:0], ~diff[33]};
      counter <= counter + CW'(1);
      if (done) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hilo_unit.sv
// Owner of architectural HI/LO: MTHI/MTLO commit, 1-cycle MULT/MULTU, iterative DIV/DIVU.
// Latency: MT* visible next cycle, MULT 2 cycles, DIV 34 cycles after accept.
// Backpressure: busy high while an op is in flight; inputs are ignored until it drops.
module hilo_unit
  import hilo_unit_pkg::*;
(
  input  logic  clk,
  input  logic  resetn,
  hilo_if.slave bus
);

  hilo_state_t state;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_signed;
  logic        quot_neg;
  logic        rem_neg;

  logic        accept;
  logic        is_mul;
  logic        is_div;
  logic        in_signed;
  logic [31:0] abs_vs;
  logic [31:0] abs_vt;
  logic        div_start;
  logic        div_done;
  logic [31:0] div_quot;
  logic [31:0] div_rem;
  logic [63:0] product;

  assign accept    = bus.in_valid && !bus.flush && (state == IDLE);
  assign is_mul    = (bus.md_op == MD_MULT) || (bus.md_op == MD_MULTU);
  assign is_div    = (bus.md_op == MD_DIV)  || (bus.md_op == MD_DIVU);
  assign in_signed = (bus.md_op == MD_MULT) || (bus.md_op == MD_DIV);
  assign abs_vs    = neg_if(in_signed && bus.vs[31], bus.vs);
  assign abs_vt    = neg_if(in_signed && bus.vt[31], bus.vt);
  assign div_start = accept && is_div;

  // Sign-extending both operands to 64 bits lets one multiplier serve MULT and MULTU.
  assign product = {{32{op_signed && op_a[31]}}, op_a} * {{32{op_signed && op_b[31]}}, op_b};

  div_radix2 u_div (
    .clk      (clk),
    .resetn   (resetn),
    .start    (div_start),
    .abort    (bus.flush),
    .dividend (abs_vs),
    .divisor  (abs_vt),
    .done     (div_done),
    .quot     (div_quot),
    .rem      (div_rem)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_signed <= 1'b0;
      quot_neg  <= 1'b0;
      rem_neg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              op_a      <= bus.vs;
              op_b      <= bus.vt;
              op_signed <= in_signed;
              state     <= MUL;
            end else if (is_div) begin
              op_a     <= bus.vs;
              op_b     <= bus.vt;
              quot_neg <= in_signed && (bus.vs[31] ^ bus.vt[31]);
              rem_neg  <= in_signed && bus.vs[31];
              state    <= DIV;
            end else begin
              if (bus.write_hilo.valid_hi) hi_q <= bus.write_hilo.hi;
              if (bus.write_hilo.valid_lo) lo_q <= bus.write_hilo.lo;
            end
          end
        end
        MUL: begin
          if (!bus.flush) begin
            hi_q <= product[63:32];
            lo_q <= product[31:0];
          end
          state <= IDLE;
        end
        DIV: begin
          if (bus.flush) begin
            state <= IDLE;
          end else if (div_done) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!bus.flush) begin
            // Divide by zero returns raw dividend / all-ones, bypassing sign fixup.
            if (op_b == 32'd0) begin
              hi_q <= op_a;
              lo_q <= 32'hFFFF_FFFF;
            end else begin
              hi_q <= neg_if(rem_neg, div_rem);
              lo_q <= neg_if(quot_neg, div_quot);
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit; stimulus queues expected HI/LO/busy length, a negedge monitor checks them.
module tb_hilo_unit;
  import hilo_unit_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    int          len;
  } exp_t;

  logic  clk;
  logic  resetn;
  hilo_if bus();

  hilo_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  string       name_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        active = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction

  // Monitor: an accept is recognised from the interface, then hi/lo/busy are checked when busy drops.
  initial begin
    exp_t  cur;
    string nm;
    int    busy_cnt;
    int    unstable;
    busy_cnt = 0;
    unstable = 0;
    forever begin
      @(negedge clk);
      if (active) begin
        if (bus.busy) begin
          busy_cnt++;
          if (bus.hi !== cur.pre_hi || bus.lo !== cur.pre_lo) unstable++;
        end else begin
          check({nm, " hi"}, bus.hi, cur.hi);
          check({nm, " lo"}, bus.lo, cur.lo);
          check({nm, " busy_len"}, busy_cnt, cur.len);
          check({nm, " hold"}, unstable, 0);
          active = 1'b0;
        end
      end
      if (!active && resetn && bus.in_valid && !bus.flush && !bus.busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_accept", 1, 0);
        end else begin
          cur      = exp_q.pop_front();
          nm       = name_q.pop_front();
          busy_cnt = 0;
          unstable = 0;
          active   = 1'b1;
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_op(string nm, logic [31:0] h, logic [31:0] l, int len);
    exp_t e;
    e.hi = h; e.lo = l; e.pre_hi = m_hi; e.pre_lo = m_lo; e.len = len;
    exp_q.push_back(e);
    name_q.push_back(nm);
    m_hi = h;
    m_lo = l;
  endtask

  task automatic idle_inputs();
    bus.in_valid   = 1'b0;
    bus.md_op      = MD_NONE;
    bus.write_hilo = '0;
    bus.vs         = '0;
    bus.vt         = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic drive(mdop_t op, logic vh, logic vl, logic [31:0] a, logic [31:0] b);
    bus.in_valid            = 1'b1;
    bus.md_op               = op;
    bus.write_hilo.valid_hi = vh;
    bus.write_hilo.valid_lo = vl;
    bus.write_hilo.hi       = a;
    bus.write_hilo.lo       = b;
    bus.vs                  = a;
    bus.vt                  = b;
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    while (bus.busy && n < 60) begin
      cyc(1);
      n++;
    end
    if (bus.busy) begin
      checks++;
      failures++;
      $display("FAIL %s timeout busy=1 required=0", nm);
    end
  endtask

  task automatic issue(string nm, mdop_t op, logic vh, logic vl, logic [31:0] a, logic [31:0] b);
    drive(op, vh, vl, a, b);
    cyc(1);
    idle_inputs();
    wait_idle(nm);
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();
    cyc(2);
    resetn = 1'b1;
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);

    expect_op("mthi", 32'h1234_5678, 32'h0, 0);
    issue("mthi", MD_NONE, 1'b1, 1'b0, 32'h1234_5678, 32'h0);
    expect_op("mtlo", 32'h1234_5678, 32'hCAFE_BABE, 0);
    issue("mtlo", MD_NONE, 1'b0, 1'b1, 32'h0, 32'hCAFE_BABE);
    expect_op("mt_both", 32'hA5A5_A5A5, 32'h5A5A_5A5A, 0);
    issue("mt_both", MD_NONE, 1'b1, 1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A);

    expect_op("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
    issue("mult", MD_MULT, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h2);
    expect_op("multu", 32'h1, 32'hFFFF_FFFE, 1);
    issue("multu", MD_MULTU, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h2);
    expect_op("mult_minmin", 32'h4000_0000, 32'h0, 1);
    issue("mult_minmin", MD_MULT, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000);

    expect_op("divu_100_7", 32'd2, 32'd14, 33);
    issue("divu_100_7", MD_DIVU, 1'b0, 1'b0, 32'd100, 32'd7);
    expect_op("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    issue("div_m7_2", MD_DIV, 1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2);
    expect_op("div_7_m2", 32'd1, 32'hFFFF_FFFD, 33);
    issue("div_7_m2", MD_DIV, 1'b0, 1'b0, 32'd7, 32'hFFFF_FFFE);
    expect_op("div_ovf", 32'h0, 32'h8000_0000, 33);
    issue("div_ovf", MD_DIV, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    expect_op("divu_5_0", 32'd5, 32'hFFFF_FFFF, 33);
    issue("divu_5_0", MD_DIVU, 1'b0, 1'b0, 32'd5, 32'd0);
    expect_op("div_m5_0", 32'hFFFF_FFFB, 32'hFFFF_FFFF, 33);
    issue("div_m5_0", MD_DIV, 1'b0, 1'b0, 32'hFFFF_FFFB, 32'd0);

    // Flush in the tenth DIV cycle: busy for 10 cycles, HI/LO untouched.
    expect_op("div_flush", m_hi, m_lo, 10);
    drive(MD_DIV, 1'b0, 1'b0, 32'd1000, 32'd7);
    cyc(1);
    idle_inputs();
    cyc(9);
    bus.flush = 1'b1;
    cyc(1);
    bus.flush = 1'b0;
    wait_idle("div_flush");

    drive(MD_NONE, 1'b1, 1'b1, 32'h0BAD_0BAD, 32'h0BAD_0BAD);
    bus.flush = 1'b1;
    cyc(1);
    idle_inputs();
    cyc(1);
    check("idle_flush hi", bus.hi, m_hi);
    check("idle_flush lo", bus.lo, m_lo);

    // MTHI held under stall commits on the first non-busy cycle, after the DIVU result.
    expect_op("divu_held", 32'd2, 32'd6, 33);
    expect_op("held_mthi", 32'hDEAD_BEEF, 32'd6, 0);
    drive(MD_DIVU, 1'b0, 1'b0, 32'd50, 32'd8);
    cyc(1);
    drive(MD_NONE, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0);
    wait_idle("divu_held");
    cyc(1);
    idle_inputs();
    cyc(1);

    expect_op("mult_reset", 32'h0, 32'h0, 1);
    drive(MD_MULT, 1'b0, 1'b0, 32'd3, 32'd4);
    cyc(1);
    idle_inputs();
    resetn = 1'b0;
    cyc(1);
    resetn = 1'b1;
    wait_idle("mult_reset");

    expect_op("mt_pre", 32'h0000_1234, 32'h0000_5678, 0);
    issue("mt_pre", MD_NONE, 1'b1, 1'b1, 32'h0000_1234, 32'h0000_5678);
    expect_op("div_reset", 32'h0, 32'h0, 5);
    drive(MD_DIVU, 1'b0, 1'b0, 32'd1000, 32'd3);
    cyc(1);
    idle_inputs();
    cyc(4);
    resetn = 1'b0;
    cyc(1);
    resetn = 1'b1;
    wait_idle("div_reset");

    expect_op("divu_9_3", 32'd0, 32'd3, 33);
    issue("divu_9_3", MD_DIVU, 1'b0, 1'b0, 32'd9, 32'd3);

    cyc(3);
    check("scoreboard drained", exp_q.size() + int'(active), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
